instr_sequencer: RTL and testbench

Upstream instruction-issue stage for the 16-bit multi-cycle processor. Holds a small loadable program memory and a program counter. Presents one instruction word at a time on the processor's `DIN`, pulses `Run` to start it, waits for the processor's `Done`, then advances. Stops after a programmed last address and reports completion and an instruction count.

---
 rtl/proc_pkg.sv | 20 ++
 rtl/instr_ram.sv | 25 ++
 rtl/instr_sequencer.sv | 123 ++++++++++++
 tb/tb_instr_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit multi-cycle processor and its issue stage.
package proc_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_HALT  = 3'd4
   } seq_state_t;

   // Processor opcodes live in instruction bits [15:13].
   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVT = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

endpackage

// File: rtl/instr_ram.sv
// Program memory: synchronous write, asynchronous read, contents not reset.
module instr_ram #(
   parameter int ADDR_W = 5,
   parameter int WORD_W = 16
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WORD_W-1:0] rd_data
);

   logic [WORD_W-1:0] mem [2**ADDR_W];

   // Write port; the array has no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction-issue stage: steps a program counter through program memory,
// handing one word at a time to the processor and waiting for its Done.
module instr_sequencer #(
   parameter int ADDR_W = 5,
   parameter int WORD_W = proc_pkg::WORD_W,
   parameter int CNT_W  = 16
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Start,
   input  logic [ADDR_W-1:0] LastAddr,
   input  logic              LoadEn,
   input  logic [ADDR_W-1:0] LoadAddr,
   input  logic [WORD_W-1:0] LoadData,
   input  logic              Done,
   output logic [WORD_W-1:0] DIN,
   output logic              Run,
   output logic [ADDR_W-1:0] PC,
   output logic              Busy,
   output logic              Halted,
   output logic [CNT_W-1:0]  Retired
);

   localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   proc_pkg::seq_state_t state_q, state_d;
   logic [ADDR_W-1:0]    last_q, last_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [WORD_W-1:0]    din_q, din_d;
   logic                 run_q, run_d;
   logic [CNT_W-1:0]     retired_q, retired_d;
   logic [WORD_W-1:0]    rd_data;
   logic                 wr_en;
   logic                 idle_like;

   // Loading is only allowed while no instruction is in flight.
   assign idle_like = (state_q == proc_pkg::ST_IDLE) || (state_q == proc_pkg::ST_HALT);
   assign wr_en     = LoadEn && idle_like;

   instr_ram #(
      .ADDR_W (ADDR_W),
      .WORD_W (WORD_W)
   ) u_ram (
      .clk     (Clock),
      .wr_en   (wr_en),
      .wr_addr (LoadAddr),
      .wr_data (LoadData),
      .rd_addr (pc_q),
      .rd_data (rd_data)
   );

   // Next-state logic: start/restart, fetch, one-cycle issue, wait for Done.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      pc_d      = pc_q;
      din_d     = din_q;
      retired_d = retired_q;
      case (state_q)
         proc_pkg::ST_IDLE, proc_pkg::ST_HALT: begin
            if (Start) begin
               last_d    = LastAddr;
               pc_d      = '0;
               retired_d = '0;
               state_d   = proc_pkg::ST_FETCH;
            end
         end
         proc_pkg::ST_FETCH: begin
            din_d   = rd_data;
            state_d = proc_pkg::ST_ISSUE;
         end
         proc_pkg::ST_ISSUE: begin
            state_d = proc_pkg::ST_WAIT;
         end
         proc_pkg::ST_WAIT: begin
            if (Done) begin
               if (retired_q != '1) begin
                  retired_d = retired_q + CNT_ONE;
               end
               if (pc_q == last_q) begin
                  state_d = proc_pkg::ST_HALT;
               end else begin
                  pc_d    = pc_q + PC_ONE;
                  state_d = proc_pkg::ST_FETCH;
               end
            end
         end
         default: begin
            state_d = proc_pkg::ST_IDLE;
         end
      endcase
      run_d = (state_d == proc_pkg::ST_ISSUE);
   end

   // State and registered outputs; reset clears everything except memory.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q   <= proc_pkg::ST_IDLE;
         last_q    <= '0;
         pc_q      <= '0;
         din_q     <= '0;
         run_q     <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         pc_q      <= pc_d;
         din_q     <= din_d;
         run_q     <= run_d;
         retired_q <= retired_d;
      end
   end

   assign DIN     = din_q;
   assign Run     = run_q;
   assign PC      = pc_q;
   assign Retired = retired_q;
   assign Busy    = (state_q == proc_pkg::ST_FETCH) || (state_q == proc_pkg::ST_ISSUE) ||
                    (state_q == proc_pkg::ST_WAIT);
   assign Halted  = (state_q == proc_pkg::ST_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a processor stand-in answers each Run with Done
// after a chosen latency, and a memory image plus issue-order rules predict
// every word, PC, count and status flag.
module tb_instr_sequencer;

   logic        Clock = 1'b0;
   logic        Resetn = 1'b0;
   logic        Start = 1'b0;
   logic [4:0]  LastAddr = '0;
   logic        LoadEn = 1'b0;
   logic [4:0]  LoadAddr = '0;
   logic [15:0] LoadData = '0;
   logic        Done = 1'b0;
   logic [15:0] DIN;
   logic        Run;
   logic [4:0]  PC;
   logic        Busy;
   logic        Halted;
   logic [15:0] Retired;

   logic [15:0] model_mem [32];
   int          lat_tab [32];
   int          tests = 0;
   int          fails = 0;

   instr_sequencer #(
      .ADDR_W (5),
      .WORD_W (16),
      .CNT_W  (16)
   ) dut (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .Start    (Start),
      .LastAddr (LastAddr),
      .LoadEn   (LoadEn),
      .LoadAddr (LoadAddr),
      .LoadData (LoadData),
      .Done     (Done),
      .DIN      (DIN),
      .Run      (Run),
      .PC       (PC),
      .Busy     (Busy),
      .Halted   (Halted),
      .Retired  (Retired)
   );

   // 10 ns clock
   always #5 Clock = ~Clock;

   task automatic do_reset();
      @(negedge Clock);
      Resetn = 1'b0;
      Start  = 1'b0;
      Done   = 1'b0;
      LoadEn = 1'b0;
      @(negedge Clock);
      Resetn = 1'b1;
   endtask

   task automatic load_word(input int a, input logic [15:0] d);
      @(negedge Clock);
      LoadEn   = 1'b1;
      LoadAddr = 5'(a);
      LoadData = d;
      model_mem[a] = d;
      @(negedge Clock);
      LoadEn = 1'b0;
   endtask

   // Runs addresses 0..last, answering each Run after lat_tab[i] cycles.
   task automatic run_program(input int last, input bit spur, input bit hold,
                              input bit wr_wait, input bit wr_start, input logic [15:0] wd);
      int          cnt;
      bit          seen;
      logic [15:0] exp_din;
      @(negedge Clock);
      LastAddr = 5'(last);
      Start    = 1'b1;
      LoadEn   = 1'b0;
      if (wr_start) begin
         LoadEn       = 1'b1;
         LoadAddr     = 5'd0;
         LoadData     = wd;
         model_mem[0] = wd;
      end
      for (int i = 0; i <= last; i++) begin
         cnt  = 0;
         seen = 1'b0;
         while (!seen && cnt < 8) begin
            @(negedge Clock);
            cnt++;
            LoadEn = 1'b0;
            if (!hold) Start = 1'b0;
            Done = spur;
            if (cnt == 1) begin
               tests++;
               if (PC !== 5'(i) || Retired !== 16'(i) || Busy !== 1'b1 || Halted !== 1'b0) begin
                  fails++;
                  $display("[TB] FAIL fetch_state i=%0d: PC=%0d Retired=%0d Busy=%b Halted=%b, required PC=%0d Retired=%0d Busy=1 Halted=0",
                           i, PC, Retired, Busy, Halted, i, i);
               end
            end
            if (Run === 1'b1) seen = 1'b1;
         end
         tests++;
         if (!seen || cnt != 2) begin
            fails++;
            $display("[TB] FAIL run_gap i=%0d: Run after %0d cycles (seen=%b), required 2", i, cnt, seen);
         end
         if (!seen) begin
            Done  = 1'b0;
            Start = 1'b0;
            return;
         end
         exp_din = model_mem[i];
         tests++;
         if (DIN !== exp_din || PC !== 5'(i)) begin
            fails++;
            $display("[TB] FAIL issue i=%0d: DIN=%h PC=%0d, required DIN=%h PC=%0d", i, DIN, PC, exp_din, i);
         end
         for (int w = 1; w <= lat_tab[i]; w++) begin
            @(negedge Clock);
            LoadEn = 1'b0;
            Done   = (w == lat_tab[i]);
            tests++;
            if (Run !== 1'b0 || DIN !== exp_din || PC !== 5'(i)) begin
               fails++;
               $display("[TB] FAIL wait i=%0d w=%0d: Run=%b DIN=%h PC=%0d, required Run=0 DIN=%h PC=%0d",
                        i, w, Run, DIN, PC, exp_din, i);
            end
            if (wr_wait && i == 0 && w == 1) begin
               LoadEn   = 1'b1;
               LoadAddr = 5'd1;
               LoadData = ~model_mem[1];
            end
         end
      end
      @(negedge Clock);
      Done   = 1'b0;
      LoadEn = 1'b0;
      if (!hold) Start = 1'b0;
      tests++;
      if (Halted !== 1'b1 || Busy !== 1'b0 || Retired !== 16'(last + 1) || PC !== 5'(last) || Run !== 1'b0) begin
         fails++;
         $display("[TB] FAIL halt: Halted=%b Busy=%b Retired=%0d PC=%0d Run=%b, required Halted=1 Busy=0 Retired=%0d PC=%0d Run=0",
                  Halted, Busy, Retired, PC, Run, last + 1, last);
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge Clock);
      tests++;
      if (DIN !== 16'h0 || Run !== 1'b0 || PC !== 5'd0 || Busy !== 1'b0 || Halted !== 1'b0 || Retired !== 16'd0) begin
         fails++;
         $display("[TB] FAIL reset_values: DIN=%h Run=%b PC=%0d Busy=%b Halted=%b Retired=%0d, required all zero",
                  DIN, Run, PC, Busy, Halted, Retired);
      end
      load_word(0, 16'h1234);
      load_word(1, 16'h5678);
      @(negedge Clock);
      LastAddr = 5'd1;
      Start    = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      Done = 1'b1;
      @(negedge Clock);
      Done = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      tests++;
      if (PC !== 5'd1 || Retired !== 16'd1 || Busy !== 1'b1 || DIN !== 16'h5678) begin
         fails++;
         $display("[TB] FAIL pre_reset_wait: PC=%0d Retired=%0d Busy=%b DIN=%h, required PC=1 Retired=1 Busy=1 DIN=5678",
                  PC, Retired, Busy, DIN);
      end
      Resetn = 1'b0;
      #1;
      tests++;
      if (DIN !== 16'h0 || Run !== 1'b0 || PC !== 5'd0 || Busy !== 1'b0 || Halted !== 1'b0 || Retired !== 16'd0) begin
         fails++;
         $display("[TB] FAIL async_reset: DIN=%h Run=%b PC=%0d Busy=%b Halted=%b Retired=%0d, required all zero",
                  DIN, Run, PC, Busy, Halted, Retired);
      end
      @(negedge Clock);
      Resetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clock);
         tests++;
         if (Busy !== 1'b0 || Run !== 1'b0 || Halted !== 1'b0 || PC !== 5'd0) begin
            fails++;
            $display("[TB] FAIL idle_after_reset k=%0d: Busy=%b Run=%b Halted=%b PC=%0d, required 0 0 0 0",
                     k, Busy, Run, Halted, PC);
         end
      end
   endtask

   task automatic test_three_instr();
      load_word(0, {proc_pkg::OP_MV,  13'h0005});
      load_word(1, {proc_pkg::OP_MVT, 13'h0007});
      load_word(2, {proc_pkg::OP_ADD, 13'h0200});
      for (int i = 0; i < 32; i++) lat_tab[i] = 1;
      run_program(2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge Clock);
         tests++;
         if (Run !== 1'b0 || Halted !== 1'b1 || Retired !== 16'd3) begin
            fails++;
            $display("[TB] FAIL stay_halted k=%0d: Run=%b Halted=%b Retired=%0d, required 0 1 3", k, Run, Halted, Retired);
         end
      end
   endtask

   task automatic test_done_latency();
      for (int i = 0; i < 32; i++) lat_tab[i] = (i % 2 == 0) ? 1 : 3;
      load_word(3, 16'h6003);
      run_program(3, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic test_writes_during_run();
      load_word(0, 16'h1111);
      load_word(1, 16'h2222);
      load_word(2, 16'h3333);
      for (int i = 0; i < 32; i++) lat_tab[i] = 2;
      run_program(2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      load_word(1, 16'hABCD);
      run_program(2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5A5A);
   endtask

   task automatic test_spurious_done();
      for (int i = 0; i < 32; i++) lat_tab[i] = 2;
      run_program(3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic test_full_depth();
      for (int a = 0; a < 32; a++) load_word(a, 16'($urandom));
      for (int i = 0; i < 32; i++) lat_tab[i] = 1;
      run_program(31, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic test_random();
      int last;
      for (int r = 0; r < 4; r++) begin
         last = int'($urandom_range(7, 0));
         for (int a = 0; a <= last; a++) load_word(a, 16'($urandom));
         for (int i = 0; i < 32; i++) lat_tab[i] = int'($urandom_range(4, 1));
         run_program(last, 1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b0, 16'h0);
      end
   endtask

   task automatic test_start_held();
      for (int i = 0; i < 32; i++) lat_tab[i] = 1;
      run_program(1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      @(negedge Clock);
      tests++;
      if (Halted !== 1'b0 || Busy !== 1'b1 || PC !== 5'd0 || Retired !== 16'd0 || Run !== 1'b0) begin
         fails++;
         $display("[TB] FAIL restart: Halted=%b Busy=%b PC=%0d Retired=%0d Run=%b, required 0 1 0 0 0",
                  Halted, Busy, PC, Retired, Run);
      end
      @(negedge Clock);
      tests++;
      if (Run !== 1'b1 || DIN !== model_mem[0]) begin
         fails++;
         $display("[TB] FAIL restart_issue: Run=%b DIN=%h, required Run=1 DIN=%h", Run, DIN, model_mem[0]);
      end
      Start = 1'b0;
      do_reset();
   endtask

   initial begin
      test_reset();
      test_three_instr();
      test_done_latency();
      test_writes_during_run();
      test_spurious_done();
      test_full_depth();
      test_random();
      test_start_held();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
